fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

- Round-robin, burst-limited arbiter for the write port of the asynchronous N-deep FIFO.
- Shares the write port among N_REQ producers in the write clock domain.
- Grants one requester at a time and passes that requester's words through while the FIFO reports space.
- Rotates priority after a burst limit, or when the granted requester goes idle.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, word width; matches the FIFO.
- MAX_BURST, 4, maximum words per grant (1..255).

Ports (one clock; reset is asynchronous and active-low; clock clk_i, reset rst_ni as the codebase does):
- clk_i  input  1  write-domain clock.
- rst_ni  input  1  asynchronous active-low reset.
- req_valid_i  input  N_REQ  per-requester word valid.
- req_data_i  input  N_REQ*DATA_WIDTH  per-requester words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready_o  output  N_REQ  per-requester word accepted this cycle.
- grant_o  output  N_REQ  one-hot current grant; all-zero in IDLE.
- fifo_we_o  output  1  FIFO write enable.
- fifo_din_o  output  DATA_WIDTH  FIFO write data.
- fifo_wrdy_i  input  1  FIFO not full.
- xfer_cnt_o  output  N_REQ*16  per-requester accepted-word counters; requester i at [i*16 +: 16].

## Operation
- FSM states: IDLE, GRANT. Registers:
  - gnt_idx, $clog2(N_REQ) bits.
  - last_idx, same width.
  - burst_cnt, 8 bits.
- IDLE:
  - If any req_valid_i is set, select the first set bit scanning from last_idx+1 upward, modulo N_REQ.
  - Load gnt_idx with the selected index, clear burst_cnt, go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, g = gnt_idx:
  - xfer = req_valid_i[g] & fifo_wrdy_i.
  - fifo_we_o = xfer.
  - req_ready_o[g] = xfer; all other ready bits are 0.
  - fifo_din_o = word g.
- Grant release, in GRANT; each condition moves to IDLE next edge and sets last_idx = g:
  - req_valid_i[g] = 0: requester done.
  - xfer and burst_cnt == MAX_BURST-1: burst limit reached.
- Otherwise, on xfer, burst_cnt increments.
- fifo_wrdy_i = 0 in GRANT: hold the grant, no transfer, burst_cnt unchanged. No timeout.
- Requester valid rules:
  - Once a word is presented, valid and data are held until ready is seen.
  - Dropping valid while granted ends the grant and transfers nothing.
- Outside GRANT:
  - fifo_we_o = 0.
  - req_ready_o = 0.
  - fifo_din_o = 0.
- Wrap-around: priority index wraps from N_REQ-1 to 0.

## Timing
- Reset values, asynchronous and immediate:
  - Registers: state IDLE, last_idx = N_REQ-1 (so requester 0 has first priority), burst_cnt = 0, gnt_idx = 0.
  - Outputs: fifo_we_o = 0, fifo_din_o = 0, req_ready_o = 0, grant_o = 0, xfer_cnt_o = 0.
- Latency:
  - valid rising in IDLE at edge t gives a grant after edge t+1.
  - First transfer in that cycle if fifo_wrdy_i = 1.
  - Data path is combinational; fifo_we_o, fifo_din_o and req_ready_o depend combinationally on req_valid_i and fifo_wrdy_i.
- Throughput:
  - One word per cycle within a burst.
  - One IDLE bubble cycle between grants.
  - Sustained maximum is MAX_BURST/(MAX_BURST+1).
- Simultaneous events:
  - Last burst word and valid drop in the same cycle: a single release; last_idx = g.
  - Multiple requests in IDLE: round-robin order only.
- Reset mid-burst: the in-flight cycle's word is not written, and all state returns to its reset value.

## Configuration
- Macro FIFO_WR_ARB_STATS_EN.
- Defined:
  - Per-requester 16-bit counters increment on each req_ready_o[i].
  - Counters wrap 0xFFFF to 0 and are cleared by reset.
- Undefined:
  - No counter flops are built; xfer_cnt_o is tied to 0.
  - Port list unchanged.

## Test plan
- Reset then single requester: req_valid_i = 4'b0001 with data 0x11..0x16, fifo_wrdy_i = 1, MAX_BURST = 4.
  - Writes 0x11-0x14 on consecutive cycles, one IDLE cycle, then 0x15-0x16.
  - grant_o = 0001 throughout each GRANT.
- All four requesters valid continuously, MAX_BURST = 4.
  - Grant order 0,1,2,3,0; each grant yields 4 writes.
  - fifo_we_o low exactly one cycle between grants.
- Backpressure: requester 2 granted, fifo_wrdy_i = 0 for 5 cycles mid-burst.
  - fifo_we_o and req_ready_o low; grant_o holds 0100; burst_cnt is frozen.
  - Burst resumes and totals 4 words.
- Requester 1 drops valid after 2 words while requester 3 is waiting.
  - Release; after the IDLE cycle grant_o = 1000.
  - Next IDLE scan starts at index 2.
- rst_ni asserted mid-burst at word 2.
  - All outputs are 0 immediately.
  - After release, requester 0 has priority again.
- With FIFO_WR_ARB_STATS_EN defined, 10 words from requester 0 and 3 from requester 2: xfer_cnt_o shows 10 and 3.
- Without FIFO_WR_ARB_STATS_EN, the same stimulus gives xfer_cnt_o = 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among N_REQ producers.
// Define FIFO_WR_ARB_STATS_EN to build the per-requester accepted-word counters.
//
// state | meaning
// Idle  | no grant; scan for the next requester after lastIdx
// Grant | gntIdx owns the write port until it drops valid or hits MAX_BURST words
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_REQ-1:0]              req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data_i,
  output logic [N_REQ-1:0]              req_ready_o,
  output logic [N_REQ-1:0]              grant_o,
  output logic                          fifo_we_o,
  output logic [DATA_WIDTH-1:0]         fifo_din_o,
  input  logic                          fifo_wrdy_i,
  output logic [N_REQ*16-1:0]           xfer_cnt_o
);

  localparam int IdxW = $clog2(N_REQ);
  localparam logic [IdxW-1:0] LastRst   = IdxW'(N_REQ - 1);
  localparam logic [7:0]      BurstLast = 8'(MAX_BURST - 1);

  typedef enum logic {Idle, Grant} state_e;

  state_e          state;
  logic [IdxW-1:0] gntIdx;
  logic [IdxW-1:0] lastIdx;
  logic [7:0]      burstCnt;
  logic [N_REQ-1:0] grantQ;

  logic [IdxW-1:0] pickIdx;
  logic [IdxW-1:0] candIdx;
  logic            pickHit;
  logic            gntValid;
  logic            xfer;

  // Walk offsets from farthest to nearest so the nearest valid requester after lastIdx wins.
  always_comb begin
    pickIdx = '0;
    candIdx = '0;
    pickHit = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      candIdx = IdxW'((int'(lastIdx) + k) % N_REQ);
      if (req_valid_i[candIdx]) begin
        pickIdx = candIdx;
        pickHit = 1'b1;
      end
    end
  end

  assign gntValid = req_valid_i[gntIdx];
  assign xfer     = (state == Grant) && gntValid && fifo_wrdy_i;

  always_comb begin
    req_ready_o = '0;
    if (xfer) req_ready_o[gntIdx] = 1'b1;
    fifo_we_o  = xfer;
    fifo_din_o = '0;
    if (state == Grant) fifo_din_o = req_data_i[gntIdx*DATA_WIDTH +: DATA_WIDTH];
  end

  assign grant_o = grantQ;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= Idle;
      gntIdx   <= '0;
      lastIdx  <= LastRst;
      burstCnt <= '0;
      grantQ   <= '0;
    end else begin
      case (state)
        Idle: begin
          if (pickHit) begin
            gntIdx          <= pickIdx;
            burstCnt        <= '0;
            grantQ          <= '0;
            grantQ[pickIdx] <= 1'b1;
            state           <= Grant;
          end
        end
        Grant: begin
          // A dropped valid and a final burst word release identically, so one branch covers both.
          if (!gntValid || (xfer && burstCnt == BurstLast)) begin
            lastIdx <= gntIdx;
            grantQ  <= '0;
            state   <= Idle;
          end else if (xfer) begin
            burstCnt <= burstCnt + 8'd1;
          end
        end
        default: state <= Idle;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] xferCnt [N_REQ];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_REQ; i++) xferCnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (req_ready_o[i]) xferCnt[i] <= xferCnt[i] + 16'd1;
    end
  end

  always_comb begin
    xfer_cnt_o = '0;
    for (int i = 0; i < N_REQ; i++) xfer_cnt_o[i*16 +: 16] = xferCnt[i];
  end
`else
  assign xfer_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle comparison against a grant/burst model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid_i = '0;
  logic [N*DW-1:0]  req_data_i = '0;
  logic [N-1:0]     req_ready_o;
  logic [N-1:0]     grant_o;
  logic             fifo_we_o;
  logic [DW-1:0]    fifo_din_o;
  logic             fifo_wrdy_i = 1'b1;
  logic [N*16-1:0]  xfer_cnt_o;

  fifo_wr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .grant_o(grant_o), .fifo_we_o(fifo_we_o), .fifo_din_o(fifo_din_o),
    .fifo_wrdy_i(fifo_wrdy_i), .xfer_cnt_o(xfer_cnt_o)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the port (-1 = nobody), words moved in this grant, last owner.
  int          mOwner = -1;
  int          mWords = 0;
  int          mLast  = N - 1;
  int          mCand;
  bit          mXfer;
  logic [15:0] mCnt [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mOwner = -1; mWords = 0; mLast = N - 1;
      for (int i = 0; i < N; i++) mCnt[i] = '0;
    end else if (mOwner >= 0) begin
      mXfer = req_valid_i[mOwner] && fifo_wrdy_i;
      if (mXfer) mCnt[mOwner] = mCnt[mOwner] + 16'd1;
      if (!req_valid_i[mOwner]) begin
        mLast = mOwner; mOwner = -1;
      end else if (mXfer) begin
        mWords++;
        if (mWords == MB) begin mLast = mOwner; mOwner = -1; end
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        mCand = (mLast + k) % N;
        if (req_valid_i[mCand]) begin mOwner = mCand; mWords = 0; break; end
      end
    end
  end

  logic [N-1:0]    eGnt, eRdy;
  logic            eWe;
  logic [DW-1:0]   eDin;
  logic [N*16-1:0] eCnt;
  bit              logWe [$];
  logic [DW-1:0]   logDin [$];
  logic [N-1:0]    logGnt [$];
  int              wrCount = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      eGnt = '0; eRdy = '0; eWe = 1'b0; eDin = '0; eCnt = '0;
      if (mOwner >= 0) begin
        eGnt[mOwner] = 1'b1;
        eDin = req_data_i[mOwner*DW +: DW];
        eWe  = req_valid_i[mOwner] && fifo_wrdy_i;
        if (eWe) eRdy[mOwner] = 1'b1;
      end
`ifdef FIFO_WR_ARB_STATS_EN
      for (int i = 0; i < N; i++) eCnt[i*16 +: 16] = mCnt[i];
`endif
      chk("grant", 64'(grant_o), 64'(eGnt));
      chk("fifo_we", 64'(fifo_we_o), 64'(eWe));
      chk("ready", 64'(req_ready_o), 64'(eRdy));
      chk("fifo_din", 64'(fifo_din_o), 64'(eDin));
      chk("xfer_cnt", 64'(xfer_cnt_o), 64'(eCnt));
      logWe.push_back(fifo_we_o);
      logDin.push_back(fifo_din_o);
      logGnt.push_back(grant_o);
      if (fifo_we_o) wrCount++;
    end
  end

  // Producers: each requester presents the head of its queue and pops it when ready was seen.
  logic [DW-1:0] srcQ [N][$];
  logic [N-1:0]  dropMask = '0;
  logic [N-1:0]  rdyS;
  int            wIdx [$];

  task automatic applyIn();
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = (srcQ[i].size() > 0) && !dropMask[i];
      req_data_i[i*DW +: DW] = (srcQ[i].size() > 0) ? srcQ[i][0] : '0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    rdyS = req_ready_o;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (rdyS[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
    applyIn();
  endtask

  task automatic clearLogs();
    logWe.delete(); logDin.delete(); logGnt.delete(); wrCount = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) srcQ[i].delete();
    dropMask = '0;
    fifo_wrdy_i = 1'b1;
    applyIn();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clearLogs();
  endtask

  task automatic runUntil(input int nWr, input int budget, input string name);
    int b;
    b = 0;
    while (wrCount < nWr && b < budget) begin cycle(); b++; end
    chk(name, 64'(wrCount), 64'(nWr));
  endtask

  task automatic buildIdx();
    wIdx.delete();
    foreach (logWe[e]) if (logWe[e]) wIdx.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int f;

  initial begin
    // Reset values while reset is held
    #2;
    chk("rst_grant", 64'(grant_o), 64'h0);
    chk("rst_we", 64'(fifo_we_o), 64'h0);
    chk("rst_din", 64'(fifo_din_o), 64'h0);
    chk("rst_ready", 64'(req_ready_o), 64'h0);
    chk("rst_cnt", 64'(xfer_cnt_o), 64'h0);

    // Single requester, six words, burst of four then one bubble
    doReset();
    for (int j = 0; j < 6; j++) srcQ[0].push_back(8'h11 + 8'(j));
    applyIn();
    runUntil(6, 40, "single_words");
    repeat (3) cycle();
    buildIdx();
    for (int k = 0; k < 6; k++) begin
      chk("single_data", 64'(logDin[wIdx[k]]), 64'(8'h11 + 8'(k)));
      chk("single_gnt", 64'(logGnt[wIdx[k]]), 64'h1);
    end
    chk("single_burst_span", 64'(wIdx[3] - wIdx[0]), 64'd3);
    chk("single_bubble", 64'(wIdx[4] - wIdx[3]), 64'd2);
    chk("single_tail", 64'(wIdx[5] - wIdx[4]), 64'd1);

    // All four requesters busy: order 0,1,2,3,0 with a one-cycle bubble between grants
    doReset();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 8; j++) srcQ[i].push_back({4'(i), 4'(j)});
    applyIn();
    runUntil(20, 60, "rr_words");
    buildIdx();
    for (int k = 0; k < 20; k++) begin
      chk("rr_gnt", 64'(logGnt[wIdx[k]]), 64'(1 << ((k / 4) % 4)));
      chk("rr_data", 64'(logDin[wIdx[k]]), 64'({4'((k / 4) % 4), 4'((k / 16) * 4 + k % 4)}));
      if (k > 0) chk("rr_gap", 64'(wIdx[k] - wIdx[k-1]), (k % 4 == 0) ? 64'd2 : 64'd1);
    end

    // Backpressure for five cycles in the middle of requester 2's burst
    doReset();
    for (int j = 0; j < 6; j++) srcQ[2].push_back(8'h20 + 8'(j));
    applyIn();
    runUntil(2, 20, "bp_first");
    fifo_wrdy_i = 1'b0;
    repeat (5) cycle();
    fifo_wrdy_i = 1'b1;
    runUntil(6, 30, "bp_words");
    repeat (2) cycle();
    buildIdx();
    f = wIdx[0];
    chk("bp_span", 64'(wIdx[3] - f), 64'd8);
    for (int e = f; e <= f + 8; e++) chk("bp_hold_gnt", 64'(logGnt[e]), 64'h4);
    chk("bp_release", 64'(logGnt[wIdx[3] + 1]), 64'h0);
    chk("bp_next", 64'(wIdx[4] - wIdx[3]), 64'd2);

    // Requester 1 drops valid after two words; 3 and 0 waiting, scan resumes at index 2
    doReset();
    for (int j = 0; j < 5; j++) srcQ[1].push_back(8'h30 + 8'(j));
    for (int j = 0; j < 4; j++) srcQ[3].push_back(8'h40 + 8'(j));
    applyIn();
    runUntil(2, 20, "drop_first");
    dropMask[1] = 1'b1;
    srcQ[0].push_back(8'h50);
    applyIn();
    runUntil(7, 40, "drop_words");
    buildIdx();
    f = wIdx[1];
    chk("drop_nowrite", 64'(logWe[f + 1]), 64'h0);
    chk("drop_gnt_hold", 64'(logGnt[f + 1]), 64'h2);
    chk("drop_idle", 64'(logGnt[f + 2]), 64'h0);
    chk("drop_next_gnt", 64'(logGnt[f + 3]), 64'h8);
    chk("drop_next_data", 64'(logDin[wIdx[2]]), 64'h40);
    chk("drop_after3_gnt", 64'(logGnt[wIdx[6]]), 64'h1);
    chk("drop_after3_data", 64'(logDin[wIdx[6]]), 64'h50);

    // Reset in the middle of a burst, while word 2 is on the port
    doReset();
    for (int j = 0; j < 6; j++) srcQ[0].push_back(8'h60 + 8'(j));
    srcQ[2].push_back(8'h70);
    applyIn();
    runUntil(1, 20, "mid_first");
    #2;
    chk("mid_we_before", 64'(fifo_we_o), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_we", 64'(fifo_we_o), 64'h0);
    chk("mid_din", 64'(fifo_din_o), 64'h0);
    chk("mid_ready", 64'(req_ready_o), 64'h0);
    chk("mid_grant", 64'(grant_o), 64'h0);
    chk("mid_cnt", 64'(xfer_cnt_o), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clearLogs();
    runUntil(1, 20, "mid_after");
    buildIdx();
    chk("mid_prio_gnt", 64'(logGnt[wIdx[0]]), 64'h1);
    chk("mid_prio_data", 64'(logDin[wIdx[0]]), 64'h61);

    // Statistics: ten words from requester 0, three from requester 2
    doReset();
    for (int j = 0; j < 10; j++) srcQ[0].push_back(8'(j));
    for (int j = 0; j < 3; j++) srcQ[2].push_back(8'h80 + 8'(j));
    applyIn();
    runUntil(13, 60, "stats_words");
    repeat (2) cycle();
    #2;
`ifdef FIFO_WR_ARB_STATS_EN
    chk("stats_cnt", 64'(xfer_cnt_o), {16'd0, 16'd3, 16'd0, 16'd10});
`else
    chk("stats_cnt", 64'(xfer_cnt_o), 64'h0);
`endif

    // Randomized traffic, backpressure and occasional valid drops
    doReset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (srcQ[i].size() < 4 && $urandom_range(0, 2) == 0) srcQ[i].push_back(8'($urandom));
        if ($urandom_range(0, 39) == 0) dropMask[i] = ~dropMask[i];
      end
      fifo_wrdy_i = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
